// File: rtl/peg_l2_rs_rmii_rx_if.sv
// Packet-side output bus of the RMII receive reconciliation sublayer.
// The receiver drives it through the master modport; consumers use the slave modport.
interface peg_l2_rs_rmii_rx_if #(
    parameter int PKT_DATA_W = 8,
    parameter int PKT_SIZE_W = 16
);
    logic                  pkt_valid;
    logic                  pkt_sop;
    logic                  pkt_eop;
    logic [PKT_DATA_W-1:0] pkt_data;
    logic                  pkt_error;
    logic [PKT_SIZE_W-1:0] pkt_size;

    modport master (
        output pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_error, pkt_size
    );

    modport slave (
        input  pkt_valid, pkt_sop, pkt_eop, pkt_data, pkt_error, pkt_size
    );
endinterface

// File: rtl/peg_l2_rs_rmii_rx.sv
// RMII receive path: dibit sampling at 10/100 Mbps, preamble/SFD strip, byte assembly.
// Optional frame statistics counters are enabled by defining PEG_L2_RS_RMII_RX_STATS_EN.
module peg_l2_rs_rmii_rx #(
    parameter int PKT_DATA_W = 8,
    parameter int PKT_SIZE_W = 16
) (
    input  logic                     rmii_ref_clk,
    input  logic                     rst,
    input  logic                     config_rs_mii_speed_100_n_10,
    input  logic [1:0]               rmii_rxd,
    input  logic                     rmii_crs_dv,
    input  logic                     rmii_rx_er,
    peg_l2_rs_rmii_rx_if.master      pkt
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
    ,
    output logic [31:0]              stat_good_frames,
    output logic [31:0]              stat_bad_frames
`endif
);

    typedef enum logic [1:0] {IDLE_S, PREAMBLE_S, DATA_S, DROP_S} state_t;

    localparam logic [PKT_SIZE_W-1:0] CNT_ONE = PKT_SIZE_W'(1);

    state_t                  state_q, state_d;
    logic                    crs_q;
    logic [3:0]              div_q, div_cur;
    logic                    rise_idle, stb;
    logic                    start, take, fin;
    logic [1:0]              idx_q;
    logic [PKT_DATA_W-1:0]   asm_q, asm_nxt, held_q;
    logic                    have_held_q, sop_pend_q, low_q, err_q;
    logic [PKT_SIZE_W-1:0]   cnt_q;
    logic                    byte_done, cnt_sat, emit, emit_eop, eop_err;

    // At 10 Mbps each dibit lasts 10 ref clocks; re-phasing on the carrier
    // edge puts the strobe near the middle of every dibit.
    assign rise_idle = (state_q == IDLE_S) && rmii_crs_dv && !crs_q;
    assign div_cur   = rise_idle ? 4'd0 : div_q;
    assign stb       = config_rs_mii_speed_100_n_10 ? 1'b1 : (div_cur == 4'd4);

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            crs_q <= 1'b0;
            div_q <= 4'd0;
        end else begin
            crs_q <= rmii_crs_dv;
            div_q <= (div_cur == 4'd9) ? 4'd0 : div_cur + 4'd1;
        end
    end

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) state_q <= IDLE_S;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        take    = 1'b0;
        fin     = 1'b0;
        if (stb) begin
            case (state_q)
                IDLE_S: begin
                    if (rmii_crs_dv)
                        state_d = (rmii_rxd == 2'b01) ? PREAMBLE_S : DROP_S;
                end
                PREAMBLE_S: begin
                    if (!rmii_crs_dv)
                        state_d = IDLE_S;
                    else if (rmii_rxd == 2'b11) begin
                        state_d = DATA_S;
                        start   = 1'b1;
                    end else if (rmii_rxd != 2'b01)
                        state_d = DROP_S;
                end
                DATA_S: begin
                    // A lone low strobe is the mid-frame CRS_DV toggle; two in a row end the frame.
                    if (!rmii_crs_dv && low_q) begin
                        fin     = 1'b1;
                        state_d = IDLE_S;
                    end else
                        take = 1'b1;
                end
                DROP_S: begin
                    if (!rmii_crs_dv)
                        state_d = IDLE_S;
                end
                default: state_d = IDLE_S;
            endcase
        end
    end

    always_comb begin
        asm_nxt                      = asm_q;
        asm_nxt[{idx_q, 1'b0} +: 2]  = rmii_rxd;
    end

    assign byte_done = take && (idx_q == 2'd3);
    assign cnt_sat   = &cnt_q;
    assign emit      = have_held_q && (byte_done || fin);
    assign emit_eop  = have_held_q && fin;
    // The first low strobe of the end sequence always lands one filler dibit in
    // the assembler, so a clean frame ends with exactly one dibit pending.
    assign eop_err   = err_q || rmii_rx_er || (idx_q != 2'd1);

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            idx_q       <= 2'd0;
            asm_q       <= '0;
            held_q      <= '0;
            have_held_q <= 1'b0;
            sop_pend_q  <= 1'b0;
            low_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (start) begin
            idx_q       <= 2'd0;
            asm_q       <= '0;
            have_held_q <= 1'b0;
            sop_pend_q  <= 1'b1;
            low_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else if (take) begin
            asm_q <= asm_nxt;
            idx_q <= idx_q + 2'd1;
            low_q <= !rmii_crs_dv;
            if (rmii_rx_er)
                err_q <= 1'b1;
            if (byte_done) begin
                held_q      <= asm_nxt;
                have_held_q <= 1'b1;
                if (cnt_sat) err_q <= 1'b1;
                else         cnt_q <= cnt_q + CNT_ONE;
            end
            if (emit)
                sop_pend_q <= 1'b0;
        end else if (fin) begin
            have_held_q <= 1'b0;
            sop_pend_q  <= 1'b0;
            low_q       <= 1'b0;
        end
    end

    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            pkt.pkt_valid <= 1'b0;
            pkt.pkt_sop   <= 1'b0;
            pkt.pkt_eop   <= 1'b0;
            pkt.pkt_error <= 1'b0;
            pkt.pkt_data  <= '0;
            pkt.pkt_size  <= '0;
        end else begin
            pkt.pkt_valid <= emit;
            pkt.pkt_sop   <= emit && sop_pend_q;
            pkt.pkt_eop   <= emit_eop;
            pkt.pkt_error <= emit_eop && eop_err;
            pkt.pkt_size  <= emit_eop ? cnt_q : '0;
            if (emit)
                pkt.pkt_data <= held_q;
        end
    end

`ifdef PEG_L2_RS_RMII_RX_STATS_EN
    always_ff @(posedge rmii_ref_clk or posedge rst) begin
        if (rst) begin
            stat_good_frames <= 32'd0;
            stat_bad_frames  <= 32'd0;
        end else if (emit_eop) begin
            if (eop_err) stat_bad_frames  <= stat_bad_frames + 32'd1;
            else         stat_good_frames <= stat_good_frames + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_peg_l2_rs_rmii_rx.sv
// Directed bench for peg_l2_rs_rmii_rx: drives RMII dibit sequences and checks
// the emitted byte stream against hand-computed frames.
module tb_peg_l2_rs_rmii_rx;

    logic       rmii_ref_clk = 1'b0;
    logic       rst = 1'b1;
    logic       spd = 1'b1;
    logic [1:0] rxd = 2'b00;
    logic       crs = 1'b0;
    logic       er  = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #10 rmii_ref_clk = ~rmii_ref_clk;
    always @(posedge rmii_ref_clk) cyc <= cyc + 1;

    peg_l2_rs_rmii_rx_if #(.PKT_DATA_W(8), .PKT_SIZE_W(16)) pkt_if ();

`ifdef PEG_L2_RS_RMII_RX_STATS_EN
    logic [31:0] stat_good, stat_bad;
`endif

    peg_l2_rs_rmii_rx #(.PKT_DATA_W(8), .PKT_SIZE_W(16)) dut (
        .rmii_ref_clk                 (rmii_ref_clk),
        .rst                          (rst),
        .config_rs_mii_speed_100_n_10 (spd),
        .rmii_rxd                     (rxd),
        .rmii_crs_dv                  (crs),
        .rmii_rx_er                   (er),
        .pkt                          (pkt_if.master)
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
        ,
        .stat_good_frames             (stat_good),
        .stat_bad_frames              (stat_bad)
`endif
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic        err;
        logic [15:0] sz;
        logic [31:0] cyc;
    } rec_t;

    rec_t mq[$];

    always @(negedge rmii_ref_clk)
        if (pkt_if.pkt_valid)
            mq.push_back({pkt_if.pkt_data, pkt_if.pkt_sop, pkt_if.pkt_eop,
                          pkt_if.pkt_error, pkt_if.pkt_size, 32'(cyc)});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic dib(input logic [1:0] d, input logic c, input logic e, input int hold);
        rxd = d;
        crs = c;
        er  = e;
        repeat (hold) @(posedge rmii_ref_clk);
        #1;
    endtask

    task automatic pre(input int hold);
        repeat (28) dib(2'b01, 1'b1, 1'b0, hold);
        dib(2'b11, 1'b1, 1'b0, hold);
    endtask

    // er_k / low_k pick a dibit (0..3) to carry rx_er or a dropped crs_dv; -1 for none.
    task automatic sbyte(input logic [7:0] b, input int hold, input int er_k, input int low_k);
        for (int k = 0; k < 4; k++)
            dib(b[2*k +: 2], (k != low_k), (k == er_k), hold);
    endtask

    task automatic idle(input int n, input int hold);
        repeat (n) dib(2'b00, 1'b0, 1'b0, hold);
    endtask

    task automatic chk_frame(input string tag, input int n, input logic [31:0] bytes,
                             input logic err, input logic [15:0] sz);
        logic [31:0] b;
        b = bytes;
        chk({tag, ".count"}, 32'(mq.size()), 32'(n));
        for (int i = 0; i < n && i < mq.size(); i++) begin
            chk($sformatf("%s.data%0d", tag, i), 32'(mq[i].d), 32'(b[8*i +: 8]));
            chk($sformatf("%s.sop%0d", tag, i), 32'(mq[i].sop), 32'(i == 0));
            chk($sformatf("%s.eop%0d", tag, i), 32'(mq[i].eop), 32'(i == n - 1));
            if (i == n - 1) begin
                chk({tag, ".err"},  32'(mq[i].err), 32'(err));
                chk({tag, ".size"}, 32'(mq[i].sz),  32'(sz));
            end
        end
        mq.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".valid"}, 32'(pkt_if.pkt_valid), 32'd0);
        chk({tag, ".sop"},   32'(pkt_if.pkt_sop),   32'd0);
        chk({tag, ".eop"},   32'(pkt_if.pkt_eop),   32'd0);
        chk({tag, ".err"},   32'(pkt_if.pkt_error), 32'd0);
        chk({tag, ".data"},  32'(pkt_if.pkt_data),  32'd0);
        chk({tag, ".size"},  32'(pkt_if.pkt_size),  32'd0);
    endtask

    initial begin
        repeat (3) @(posedge rmii_ref_clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        idle(4, 1);

        // 100 Mbps reference frame
        pre(1);
        sbyte(8'h0A, 1, -1, -1);
        sbyte(8'hFF, 1, -1, -1);
        sbyte(8'h3C, 1, -1, -1);
        idle(4, 1);
        if (mq.size() >= 2) chk("f100.gap", mq[1].cyc - mq[0].cyc, 32'd4);
        else                chk("f100.gap_missing", 32'(mq.size()), 32'd2);
        chk_frame("f100", 3, 32'h003CFF0A, 1'b0, 16'd3);

        // Same frame at 10 Mbps, every dibit held 10 clocks
        spd = 1'b0;
        idle(3, 10);
        pre(10);
        sbyte(8'h0A, 10, -1, -1);
        sbyte(8'hFF, 10, -1, -1);
        sbyte(8'h3C, 10, -1, -1);
        idle(4, 10);
        if (mq.size() >= 2) chk("f10.gap", mq[1].cyc - mq[0].cyc, 32'd40);
        else                chk("f10.gap_missing", 32'(mq.size()), 32'd2);
        chk_frame("f10", 3, 32'h003CFF0A, 1'b0, 16'd3);
        spd = 1'b1;
        idle(3, 1);

        // rx_er pulse inside the second byte
        pre(1);
        sbyte(8'h0A, 1, -1, -1);
        sbyte(8'hFF, 1, 2, -1);
        sbyte(8'h3C, 1, -1, -1);
        idle(4, 1);
        chk_frame("rxer", 3, 32'h003CFF0A, 1'b1, 16'd3);
`ifdef PEG_L2_RS_RMII_RX_STATS_EN
        chk("stat.good", stat_good, 32'd2);
        chk("stat.bad",  stat_bad,  32'd1);
`endif

        // Two bytes plus a stray dibit: partial byte dropped, error flagged
        pre(1);
        sbyte(8'h0A, 1, -1, -1);
        sbyte(8'hFF, 1, -1, -1);
        dib(2'b10, 1'b1, 1'b0, 1);
        idle(4, 1);
        chk_frame("partial", 2, 32'h0000FF0A, 1'b1, 16'd2);

        // Single-strobe crs_dv drop inside a byte must not end the frame
        pre(1);
        sbyte(8'h5A, 1, -1, -1);
        sbyte(8'h12, 1, -1, 1);
        sbyte(8'h34, 1, -1, -1);
        idle(4, 1);
        chk_frame("toggle", 3, 32'h0034125A, 1'b0, 16'd3);

        // Bad preamble dibit: whole burst dropped
        repeat (5) dib(2'b01, 1'b1, 1'b0, 1);
        dib(2'b10, 1'b1, 1'b0, 1);
        repeat (4) dib(2'b01, 1'b1, 1'b0, 1);
        dib(2'b11, 1'b1, 1'b0, 1);
        sbyte(8'h0A, 1, -1, -1);
        sbyte(8'hFF, 1, -1, -1);
        idle(4, 1);
        chk("badpre.count", 32'(mq.size()), 32'd0);
        mq.delete();

        // Reset mid-frame, then a clean single-byte frame
        pre(1);
        sbyte(8'h77, 1, -1, -1);
        rxd = 2'b00;
        crs = 1'b1;
        rst = 1'b1;
        @(negedge rmii_ref_clk);
        chk_idle_outputs("midrst");
        repeat (2) @(posedge rmii_ref_clk);
        #1;
        rst = 1'b0;
        repeat (6) dib(2'b00, 1'b1, 1'b0, 1);
        idle(4, 1);
        chk("midrst.drop", 32'(mq.size()), 32'd0);
        mq.delete();
        pre(1);
        sbyte(8'hC3, 1, -1, -1);
        idle(4, 1);
        chk_frame("after_rst", 1, 32'h000000C3, 1'b0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
